// File: rtl/mips_div_pkg.sv
// Shared types, constants and arithmetic helpers for the EX-stage divider.
package mips_div_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    function automatic logic [DIV_W-1:0] div_neg(input logic [DIV_W-1:0] x);
        return (~x) + DIV_W'(1);
    endfunction

    // Magnitude of a two's-complement value; 0x80000000 wraps to itself.
    function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] x, input logic is_signed);
        return (is_signed && x[DIV_W-1]) ? div_neg(x) : x;
    endfunction

endpackage

// File: rtl/mips_div_if.sv
// EX-stage divide handshake: EX is the master, the divider the slave.
interface mips_div_if;
    import mips_div_pkg::*;

    logic               signed_div_i;
    logic [DIV_W-1:0]   opdata1_i;
    logic [DIV_W-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*DIV_W-1:0] result_o;
    logic               ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/mips_div.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU, one quotient bit per cycle.
module mips_div
    import mips_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DIV_W,
    parameter int unsigned DATA_WIDTH_LOG2 = DIV_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    mips_div_if.slave  div_bus
);

    div_state_t                  state_q, state_d;
    logic [DATA_WIDTH_LOG2-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       rem_q, rem_d;
    logic [DATA_WIDTH-1:0]       shift_q, shift_d;
    logic [DATA_WIDTH-1:0]       divisor_q, divisor_d;
    logic                        signed_q, signed_d;
    logic                        neg1_q, neg1_d;
    logic                        neg2_q, neg2_d;
    logic [2*DATA_WIDTH-1:0]     result_q, result_d;
    logic                        ready_q, ready_d;

    logic [DATA_WIDTH:0]         diff;
    logic [DATA_WIDTH-1:0]       rem_step, shift_step;
    logic [DATA_WIDTH-1:0]       quot_fix, rem_fix;

    // One restoring step; a borrow out of the 33-bit subtract means "keep the old remainder".
    always_comb begin
        diff = {rem_q, shift_q[DATA_WIDTH-1]} - {1'b0, divisor_q};
        if (!diff[DATA_WIDTH]) begin
            rem_step   = diff[DATA_WIDTH-1:0];
            shift_step = {shift_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_step   = {rem_q[DATA_WIDTH-2:0], shift_q[DATA_WIDTH-1]};
            shift_step = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end
        quot_fix = (signed_q && (neg1_q ^ neg2_q)) ? div_neg(shift_step) : shift_step;
        rem_fix  = (signed_q && neg1_q) ? div_neg(rem_step) : rem_step;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        result_d  = result_q;
        ready_d   = DivResultNotReady;

        case (state_q)
            DivFree: begin
                if (div_bus.start_i == DivStart && !div_bus.annul_i) begin
                    if (div_bus.opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        signed_d  = div_bus.signed_div_i;
                        neg1_d    = div_bus.opdata1_i[DATA_WIDTH-1];
                        neg2_d    = div_bus.opdata2_i[DATA_WIDTH-1];
                        rem_d     = '0;
                        shift_d   = div_abs(div_bus.opdata1_i, div_bus.signed_div_i);
                        divisor_d = div_abs(div_bus.opdata2_i, div_bus.signed_div_i);
                        cnt_d     = '0;
                    end
                end
            end
            DivByZero: begin
                if (div_bus.annul_i) begin
                    state_d = DivFree;
                end else begin
                    state_d  = DivEnd;
                    result_d = '0;
                end
            end
            DivOn: begin
                if (div_bus.annul_i) begin
                    state_d = DivFree;
                    cnt_d   = '0;
                end else begin
                    rem_d   = rem_step;
                    shift_d = shift_step;
                    cnt_d   = cnt_q + DATA_WIDTH_LOG2'(1);
                    if (cnt_q == '1) begin
                        state_d  = DivEnd;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            DivEnd: begin
                if (div_bus.start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    ready_d  = DivResultReady;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign div_bus.result_o = result_q;
    assign div_bus.ready_o  = ready_q;

endmodule

// File: tb/tb_mips_div.sv
// Bench for mips_div: directed vector table, multi-cycle corner sequences, random ops vs a reference model.
module tb_mips_div;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mips_div_if bus ();

    mips_div #(.DATA_WIDTH(32), .DATA_WIDTH_LOG2(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .div_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, 64-bit wide so INT_MIN/-1 just wraps.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
        return (b == 32'd0) ? 2 : 33;
    endfunction

    task automatic drive_idle();
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
    endtask

    // Issues a request and counts edges after the start-sampling edge until ready_o is seen.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                          output int edges, output logic [63:0] res);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        edges = -1;
        res   = '0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (scramble && edges == 0) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sgn;
            end
            if (bus.ready_o) begin
                res = bus.result_o;
                return;
            end
        end
        edges = 100;
    endtask

    task automatic release_op(input string name);
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_drop"}, {bus.ready_o, bus.result_o}, 65'd0);
    endtask

    task automatic watch_quiet(input int n, input string name);
        logic seen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o) seen = 1'b1;
        end
        check(name, {63'd0, seen}, 64'd0);
    endtask

    // Annuls after n iteration edges past the start-sampling edge, then verifies no result appears.
    task automatic annul_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int n,
                            input string name);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        @(posedge clk);
        repeat (n) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        watch_quiet(40, name);
    endtask

    vec_t        vecs[10];
    int          edges;
    logic [63:0] res;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33};
        vecs[3] = '{1'b1, 32'd5,          32'd0,          64'h0,                 2};
        vecs[4] = '{1'b0, 32'd5,          32'd0,          64'h0,                 2};
        vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
        vecs[6] = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 33};
        vecs[7] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
        vecs[9] = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 33};

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.ready_o, bus.result_o}, 65'd0);
        rst = 1'b0;
        watch_quiet(3, "idle_no_ready");

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, edges, res);
            check($sformatf("vec%0d_latency", i), 64'(edges), 64'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            release_op($sformatf("vec%0d", i));
        end

        // Result must stay stable while EX keeps start high past ready.
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, edges, res);
        check("hold_latency", 64'(edges), 64'd33);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold%0d", k), {bus.ready_o, bus.result_o}, {1'b1, 64'h00000000_80000000});
        end
        release_op("hold");

        annul_op(1'b0, 32'd100, 32'd7, 10, "annul_div_quiet");
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, edges, res);
        check("post_annul_latency", 64'(edges), 64'd33);
        check("post_annul_result", res, 64'h00000000_FFFFFFFF);
        release_op("post_annul");

        annul_op(1'b1, 32'd5, 32'd0, 0, "annul_byzero_quiet");
        annul_op(1'b1, 32'd77, 32'd5, 31, "annul_last_iter_quiet");

        // Reset mid-divide.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outputs", {bus.ready_o, bus.result_o}, 65'd0);
        rst = 1'b0;
        watch_quiet(40, "midreset_quiet");
        run_op(1'b0, 32'd9, 32'd3, 1'b0, edges, res);
        check("post_reset_latency", 64'(edges), 64'd33);
        check("post_reset_result", res, 64'h00000000_00000003);
        release_op("post_reset");

        for (int i = 0; i < 40; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            run_op(sgn, a, b, 1'(i % 2), edges, res);
            check($sformatf("rnd%0d_latency", i), 64'(edges), 64'(ref_lat(b)));
            check($sformatf("rnd%0d_result s=%0d a=%h b=%h", i, sgn, a, b), res, ref_div(sgn, a, b));
            release_op($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
